wb_port_arbiter: RTL

Shares the single register-file write port of the pipelined RISC-V core between the in-order WB stage and one long-latency unit (LLU: divider or cache-refill path) that completes out of order. LLU results are held in a small FIFO and drained into idle WB slots. An age counter forces a pipeline stall when an LLU result has waited too long. The block sits between the WB-stage data mux output and the register file write inputs.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_arb_fifo.sv | 74 +++++++
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the WB / long-latency-unit register-file write-port arbiter.
package wb_arb_pkg;

    localparam int ARB_XLEN = 32;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                live;
        logic [4:0]          rd;
        logic [ARB_XLEN-1:0] data;
    } fifo_entry_t;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// LLU result FIFO: DEPTH entries with per-entry live bits, kill-by-rd and a registered
// pending-destination mask.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [4:0]          push_rd,
    input  logic [ARB_XLEN-1:0] push_data,
    input  logic                pop,
    input  logic                kill,
    input  logic [4:0]          kill_rd,
    output logic                full,
    output logic                empty,
    output fifo_entry_t         head,
    output logic [31:0]         pend_mask
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    fifo_entry_t  mem   [DEPTH];
    fifo_entry_t  mem_n [DEPTH];
    logic [31:0]  mask_n;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head    = mem[rptr[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Dead slots carry live=0, so the mask can simply OR over all storage.
    always_comb begin
        mask_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_n[i] = mem[i];
            if (kill && (mem[i].rd == kill_rd))
                mem_n[i].live = 1'b0;
        end
        if (pop_ok)
            mem_n[rptr[AW-1:0]].live = 1'b0;
        if (push_ok)
            mem_n[wptr[AW-1:0]] = '{live: 1'b1, rd: push_rd, data: push_data};
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_n[i].live)
                mask_n = mask_n | rd_onehot(mem_n[i].rd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            pend_mask <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= mem_n[i];
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            pend_mask <= mask_n;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and a long-latency unit.
// Optional same-cycle LLU bypass when built with WB_ARB_BYPASS_EN.
//
//   state  | meaning
//   NORMAL | WB has priority, FIFO head drains into idle WB slots
//   STARVE | pipeline stalled, FIFO head is forced out
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            llu_valid_i,
    input  logic [4:0]      llu_rd_i,
    input  logic [XLEN-1:0] llu_data_i,
    output logic            llu_ready_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            stall_o,
    output logic [31:0]     pend_mask_o
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    if (XLEN != ARB_XLEN) begin : g_xlen_check
        $error("wb_port_arbiter: XLEN must match the FIFO entry data width");
    end

    arb_state_t       state;
    logic [AGE_W-1:0] age;
    logic             full;
    logic             empty;
    fifo_entry_t      head;
    logic             wb_grant;
    logic             head_grant;
    logic             llu_xfer;
    logic             bypass;
    logic             push;

    assign wb_grant    = (state == NORMAL) && wb_valid_i && (wb_rd_i != REG_X0);
    assign head_grant  = !empty && !wb_grant;
    assign llu_ready_o = !full && !rst;
    // x0 results are accepted on the handshake but dropped here.
    assign llu_xfer    = llu_valid_i && llu_ready_o && (llu_rd_i != REG_X0);

`ifdef WB_ARB_BYPASS_EN
    assign bypass = llu_xfer && empty && !wb_grant;
`else
    assign bypass = 1'b0;
`endif

    assign push = llu_xfer && !bypass;

    wb_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (llu_rd_i),
        .push_data (llu_data_i),
        .pop       (head_grant),
        .kill      (wb_grant),
        .kill_rd   (wb_rd_i),
        .full      (full),
        .empty     (empty),
        .head      (head),
        .pend_mask (pend_mask_o)
    );

    // A killed head is still granted and popped, it just does not write.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_rd_o    = REG_X0;
        rf_wdata_o = '0;
        if (!rst) begin
            if (wb_grant) begin
                rf_we_o    = 1'b1;
                rf_rd_o    = wb_rd_i;
                rf_wdata_o = wb_data_i;
            end else if (head_grant && head.live) begin
                rf_we_o    = 1'b1;
                rf_rd_o    = head.rd;
                rf_wdata_o = head.data;
            end else if (bypass) begin
                rf_we_o    = 1'b1;
                rf_rd_o    = llu_rd_i;
                rf_wdata_o = llu_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || empty || head_grant)
            age <= '0;
        else if (age != AGE_MAX)
            age <= age + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= NORMAL;
            stall_o <= 1'b0;
        end else begin
            case (state)
                NORMAL: begin
                    if (!empty && (age == AGE_MAX) && !head_grant) begin
                        state   <= STARVE;
                        stall_o <= 1'b1;
                    end
                end
                STARVE: begin
                    if (head_grant) begin
                        state   <= NORMAL;
                        stall_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= NORMAL;
                    stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
